baud_rate_ctrl: RTL and testbench
=================================

Name: baud_rate_ctrl

Overview:
- Run-time configuration controller for the UART oversampling-tick generator.
- Accepts baud-rate change requests (new divisor) over a valid/ready handshake and validates them.
- Holds off new frames and waits until both UART receiver and transmitter are idle.
- Then loads the divisor and restarts the tick generator cleanly, so no frame is ever sampled at a mixed rate.

Parameters:
- DVSR_W, 11, width of divisor bus (matches generator dvsr input).
- DEFAULT_DVSR, 650, divisor driven out of reset (100 MHz / (16*9600) - 1).
- MIN_DVSR, 7, smallest legal divisor; smaller requests rejected.
- CLEAR_CYC, 2, cycles the generator counter is held cleared when a new divisor is applied.
- TIMEOUT_CYC, 65535, drain timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  divisor change request valid
- req_dvsr  in  DVSR_W  requested divisor (max count of generator)
- req_ready  out  1  controller can accept a request
- rx_busy  in  1  UART receiver mid-frame
- tx_busy  in  1  UART transmitter mid-frame
- dvsr  out  DVSR_W  divisor to tick generator (registered)
- gen_clear  out  1  registered clear to tick generator counter
- cfg_busy  out  1  UART FSMs must not start a new frame while high
- cfg_done  out  1  one-cycle pulse: request completed
- cfg_err  out  1  one-cycle pulse: request rejected
- cfg_timeout  out  1  one-cycle pulse: divisor applied by drain timeout

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high; every flop resets on the clk edge with reset=1.
- Reset values:
  - state=IDLE, dvsr=DEFAULT_DVSR.
  - gen_clear=0, cfg_busy=0, cfg_done=0, cfg_err=0, cfg_timeout=0.
  - req_ready=1 (decoded from state).
- FSM states: IDLE, DRAIN, CLEAR, DONE.
- req_ready = (state==IDLE). Accept = req_valid & req_ready. Exactly one request is in flight; req_dvsr is sampled only on accept into a pending register.
- IDLE, on accept:
  - req_dvsr < MIN_DVSR: cfg_err=1 next cycle; stay IDLE; dvsr unchanged.
  - req_dvsr == current dvsr: cfg_done=1 next cycle; stay IDLE; no clear.
  - Otherwise: latch pending; go to DRAIN.
- DRAIN:
  - cfg_busy=1.
  - When rx_busy=0 and tx_busy=0 in the same cycle, go to CLEAR.
  - Busy inputs that rise while in DRAIN keep it waiting. No abort path.
- CLEAR:
  - On entry, dvsr<=pending and gen_clear=1, held exactly CLEAR_CYC cycles via a down-counter.
  - cfg_busy stays 1. Then go to DONE.
- DONE: cfg_done=1 for one cycle; gen_clear=0; cfg_busy=0; next state IDLE (req_ready=1 the following cycle).
- Latency, valid request with UART idle: accept edge -> DRAIN (1) -> CLEAR (CLEAR_CYC) -> DONE; cfg_done asserts 2+CLEAR_CYC cycles after the accept edge.
- dvsr changes only on entry to CLEAR. gen_clear and dvsr update on the same edge.
- Reset mid-operation (any state): pending request is discarded, dvsr returns to DEFAULT_DVSR, no pulses are emitted.
- cfg_done, cfg_err, cfg_timeout are mutually exclusive and never high on consecutive cycles for one request.
- Arithmetic: all compares unsigned DVSR_W; CLEAR counter width $clog2(CLEAR_CYC+1).

Optional Feature:
- Macro BAUD_TIMEOUT_EN.
- Defined:
  - A DRAIN counter starts at 0 on DRAIN entry and increments each DRAIN cycle.
  - If it reaches TIMEOUT_CYC-1 while busy persists, go to CLEAR anyway and pulse cfg_timeout on the CLEAR entry cycle.
  - If idle and timeout coincide, idle wins (no cfg_timeout).
  - cfg_done still pulses in DONE.
- Undefined: no counter logic; cfg_timeout tied 0; DRAIN waits indefinitely.

Decomposition:
- Package baud_pkg holds:
  - the state enum type baud_ctrl_state_t (IDLE, DRAIN, CLEAR, DONE);
  - the constants DVSR_W, DEFAULT_DVSR, MIN_DVSR, shared with the tick generator and the UART top.
- One natural sub-module: cfg_timer, a loadable down-counter with zero flag.
  - One instance for the CLEAR hold.
  - A second instance for the drain timeout under BAUD_TIMEOUT_EN.

Test Plan:
- Reset release -> dvsr=650, req_ready=1, gen_clear=0, all pulses 0.
- req_dvsr=325, rx_busy=tx_busy=0 -> gen_clear high 2 cycles with dvsr=325 on first; cfg_done 4 cycles after accept.
- req_dvsr=3 -> cfg_err one cycle later, dvsr stays 650, no gen_clear.
- req_dvsr=650 while dvsr=650 -> cfg_done next cycle, no CLEAR.
- req_dvsr=162 with tx_busy=1 for 40 cycles -> cfg_busy=1 throughout, dvsr unchanged until tx_busy falls, then normal CLEAR/DONE.
- BAUD_TIMEOUT_EN, TIMEOUT_CYC=16, rx_busy stuck 1 -> cfg_timeout on CLEAR entry after 16 DRAIN cycles, dvsr updated. Separately, reset asserted during CLEAR -> dvsr=650, no cfg_done.

Source files
------------

// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : baud_pkg
// Description : Shared definitions for the UART baud-rate configuration path.
//               Holds the divisor bus width, the out-of-reset divisor, the
//               smallest legal divisor and the controller state type. The
//               tick generator and the UART top use the same constants.
// Revision    : 1.0 - initial release
// ============================================================================
package baud_pkg;

  // Width of the divisor bus into the oversampling-tick generator.
  localparam int unsigned DVSR_W       = 11;
  // 100 MHz / (16 * 9600) - 1
  localparam int unsigned DEFAULT_DVSR = 650;
  // Requests below this divisor are rejected.
  localparam int unsigned MIN_DVSR     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } baud_ctrl_state_t;

endpackage : baud_pkg
`default_nettype wire

// File: rtl/baud_rate_ctrl_cfg_timer.sv
`default_nettype none
// ============================================================================
// Module      : cfg_timer
// Description : Loadable down-counter with a zero flag. Loading takes
//               priority over counting; the counter holds at zero.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset (count -> 0)
//               load_i     - load load_val_i into the counter
//               load_val_i - value to load
//               en_i       - decrement by one when non-zero
//               zero_o     - counter currently equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : cfg_timer
`default_nettype wire

// File: rtl/baud_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : baud_rate_ctrl
// Description : Run-time divisor controller for the UART oversampling-tick
//               generator. Accepts a new divisor over valid/ready, rejects
//               divisors below MIN_DVSR, acknowledges a request equal to the
//               current divisor immediately, otherwise holds off new frames
//               (cfg_busy), waits for RX and TX to go idle, then loads the
//               divisor and holds the generator counter cleared for
//               CLEAR_CYC cycles so no frame is sampled at a mixed rate.
// Config      : BAUD_TIMEOUT_EN - when defined, the drain wait is bounded by
//               TIMEOUT_CYC cycles; on expiry the divisor is applied anyway
//               and cfg_timeout pulses. When undefined cfg_timeout is 0.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_valid/req_ready - divisor request handshake
//               req_dvsr            - requested divisor
//               rx_busy, tx_busy    - UART receiver/transmitter mid-frame
//               dvsr                - registered divisor to tick generator
//               gen_clear           - registered clear to generator counter
//               cfg_busy            - UART must not start a new frame
//               cfg_done            - pulse: request completed
//               cfg_err             - pulse: request rejected
//               cfg_timeout         - pulse: divisor applied by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module baud_rate_ctrl #(
  parameter int unsigned DVSR_W       = baud_pkg::DVSR_W,
  parameter int unsigned DEFAULT_DVSR = baud_pkg::DEFAULT_DVSR,
  parameter int unsigned MIN_DVSR     = baud_pkg::MIN_DVSR,
  parameter int unsigned CLEAR_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [DVSR_W-1:0] req_dvsr,
  output logic              req_ready,
  input  logic              rx_busy,
  input  logic              tx_busy,
  output logic [DVSR_W-1:0] dvsr,
  output logic              gen_clear,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              cfg_timeout
);

  import baud_pkg::*;

  localparam int unsigned       CLR_W    = $clog2(CLEAR_CYC + 1);
  localparam logic [DVSR_W-1:0] MIN_V    = DVSR_W'(MIN_DVSR);
  localparam logic [DVSR_W-1:0] DEF_V    = DVSR_W'(DEFAULT_DVSR);
  localparam logic [CLR_W-1:0]  CLR_LOAD = CLR_W'(CLEAR_CYC - 1);

  // Reject parameter sets the timing below cannot honour.
  generate
    if ((CLEAR_CYC < 1) || (TIMEOUT_CYC < 2) || (DEFAULT_DVSR < MIN_DVSR))
    begin : g_param_err
      $error("baud_rate_ctrl: illegal parameter combination");
    end
  endgenerate

  baud_ctrl_state_t  state_q, state_d;
  logic [DVSR_W-1:0] pending_q;
  logic [DVSR_W-1:0] dvsr_q;
  logic              gen_clear_q;
  logic              cfg_busy_q;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_timeout_q, cfg_timeout_d;
  logic              accept;
  logic              latch_pending;
  logic              clr_load;
  logic              clr_zero;
  logic              drain_idle;
  logic              timeout_hit;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid & req_ready;
  assign drain_idle = ~rx_busy & ~tx_busy;

  // Counts the cycles gen_clear is held; loaded on the CLEAR entry edge.
  cfg_timer #(
    .W (CLR_W)
  ) u_clr_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (clr_load),
    .load_val_i (CLR_LOAD),
    .en_i       (state_q == CLEAR),
    .zero_o     (clr_zero)
  );

`ifdef BAUD_TIMEOUT_EN
  localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

  logic drain_start;
  logic to_zero;

  // Counting down from TIMEOUT_CYC-1 reaches zero in the same DRAIN cycle
  // an up-counter started at 0 would reach TIMEOUT_CYC-1.
  assign drain_start = (state_q == IDLE) && (state_d == DRAIN);

  cfg_timer #(
    .W (TO_W)
  ) u_drain_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (drain_start),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == DRAIN),
    .zero_o     (to_zero)
  );

  assign timeout_hit = to_zero;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cfg_done_d    = 1'b0;
    cfg_err_d     = 1'b0;
    cfg_timeout_d = 1'b0;
    latch_pending = 1'b0;
    clr_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_dvsr < MIN_V) begin
            cfg_err_d = 1'b1;
          end else if (req_dvsr == dvsr_q) begin
            // Nothing to change: acknowledge without disturbing the generator.
            cfg_done_d = 1'b1;
          end else begin
            latch_pending = 1'b1;
            state_d       = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Idle takes precedence over a coincident timeout.
        if (drain_idle) begin
          state_d  = CLEAR;
          clr_load = 1'b1;
        end else if (timeout_hit) begin
          state_d       = CLEAR;
          clr_load      = 1'b1;
          cfg_timeout_d = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cfg_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= DEF_V;
      dvsr_q        <= DEF_V;
      gen_clear_q   <= 1'b0;
      cfg_busy_q    <= 1'b0;
      cfg_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      cfg_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (latch_pending) begin
        pending_q <= req_dvsr;
      end
      // The divisor and the generator clear change on the same edge.
      if (clr_load) begin
        dvsr_q <= pending_q;
      end
      gen_clear_q   <= (state_d == CLEAR);
      cfg_busy_q    <= (state_d == DRAIN) || (state_d == CLEAR);
      cfg_done_q    <= cfg_done_d;
      cfg_err_q     <= cfg_err_d;
      cfg_timeout_q <= cfg_timeout_d;
    end
  end

  assign dvsr        = dvsr_q;
  assign gen_clear   = gen_clear_q;
  assign cfg_busy    = cfg_busy_q;
  assign cfg_done    = cfg_done_q;
  assign cfg_err     = cfg_err_q;
  assign cfg_timeout = cfg_timeout_q;

endmodule : baud_rate_ctrl
`default_nettype wire

// File: tb/tb_baud_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_rate_ctrl
// Description : Self-checking bench for baud_rate_ctrl. Each request is
//               predicted from the request rules and the busy duration:
//               reject / same-divisor acknowledge / drain-clear-done with
//               the expected cycle offsets after the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_rate_ctrl;

  localparam int DW  = 11;
  localparam int DEF = 650;
  localparam int MIN = 7;
  localparam int CLR = 2;
  localparam int TO  = 16;
`ifdef BAUD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [DW-1:0] req_dvsr = '0;
  logic          rx_busy = 1'b0;
  logic          tx_busy = 1'b0;
  logic          req_ready;
  logic [DW-1:0] dvsr;
  logic          gen_clear, cfg_busy, cfg_done, cfg_err, cfg_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = DEF;

  baud_rate_ctrl #(
    .CLEAR_CYC   (CLR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_dvsr    (req_dvsr),
    .req_ready   (req_ready),
    .rx_busy     (rx_busy),
    .tx_busy     (tx_busy),
    .dvsr        (dvsr),
    .gen_clear   (gen_clear),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .cfg_timeout (cfg_timeout)
  );

  always #5 clk = ~clk;

  // {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err, cfg_timeout}
  function automatic logic [16:0] pack(input logic rdy, input int dv,
      input logic gc, input logic bsy, input logic dn, input logic er,
      input logic tm);
    logic [DW-1:0] d;
    d = DW'(dv);
    return {rdy, d, gc, bsy, dn, er, tm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE; busy mask held for the first b cycles after accept.
  task automatic run_req(input int d, input int b, input logic [1:0] mask,
                         input string name);
    int          kind;
    int          te;
    int          h;
    bit          tmo;
    logic [16:0] exp_v, act_v;
    if (d < MIN)       kind = 0;
    else if (d == cur) kind = 1;
    else               kind = 2;
    tmo = TO_EN && (b >= TO);
    te  = tmo ? TO - 1 : b;
    h   = (kind == 2) ? te + CLR + 2 : 1;
    req_valid = 1'b1;
    req_dvsr  = DW'(d);
    tick();
    req_valid = 1'b0;
    req_dvsr  = DW'($urandom_range(0, 2047));
    for (int t = 0; t <= h; t++) begin
      case (kind)
        0:       exp_v = pack(1'b1, cur, 1'b0, 1'b0, 1'b0, t == 0, 1'b0);
        1:       exp_v = pack(1'b1, cur, 1'b0, 1'b0, t == 0, 1'b0, 1'b0);
        default: exp_v = pack(t >= te + CLR + 2,
                              (t >= te + 1) ? d : cur,
                              (t >= te + 1) && (t <= te + CLR),
                              t <= te + CLR,
                              t == te + CLR + 2,
                              1'b0,
                              tmo && (t == te + 1));
      endcase
      act_v = {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
               cfg_timeout};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s d=%0d b=%0d t=%0d: got %h expected %h",
                 name, d, b, t, act_v, exp_v);
      end
      {rx_busy, tx_busy} = (kind == 2 && t < b) ? mask : 2'b00;
      tick();
    end
    {rx_busy, tx_busy} = 2'b00;
    if (kind == 2) cur = d;
  endtask

  task automatic test_reset();
    logic [16:0] exp_v;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'(($urandom() & 1));
      req_dvsr  = DW'($urandom_range(0, 2047));
      {rx_busy, tx_busy} = 2'($urandom_range(0, 3));
      tick();
      exp_v = pack(1'b1, DEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
           cfg_timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL reset_hold: got %h expected %h",
                 {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
                  cfg_timeout}, exp_v);
      end
    end
    req_valid = 1'b0;
    {rx_busy, tx_busy} = 2'b00;
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
         cfg_timeout} !== exp_v) begin
      n_bad++;
      $display("FAIL reset_release: got %h expected %h",
               {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
                cfg_timeout}, exp_v);
    end
    cur = DEF;
  endtask

  task automatic test_reject();
    run_req(3, 0, 2'b00, "reject_3");
    run_req(0, 0, 2'b00, "reject_0");
    run_req(MIN - 1, 0, 2'b00, "reject_min_m1");
  endtask

  task automatic test_same();
    run_req(cur, 0, 2'b00, "same_dvsr");
  endtask

  task automatic test_change();
    run_req(325, 0, 2'b00, "change_325");
    run_req(MIN, 0, 2'b00, "change_min");
    run_req(2047, 0, 2'b00, "change_max");
  endtask

  task automatic test_drain();
    run_req(162, 40, 2'b01, "drain_tx40");
    run_req(200, 7, 2'b10, "drain_rx7");
    run_req(201, 1, 2'b11, "drain_both1");
  endtask

  task automatic test_timeout();
    if (TO_EN) begin
      run_req(100, 30, 2'b10, "timeout_rx_stuck");
      run_req(120, TO - 1, 2'b01, "timeout_coincide");
      run_req(130, TO, 2'b11, "timeout_edge");
    end
  endtask

  task automatic test_random();
    int d, b, r, gap;
    logic [16:0] exp_v;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       d = $urandom_range(0, MIN - 1);
      else if (r == 2) d = cur;
      else             d = $urandom_range(MIN, 2047);
      b = $urandom_range(0, TO_EN ? 24 : 12);
      run_req(d, b, 2'($urandom_range(1, 3)), "random");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        {rx_busy, tx_busy} = 2'($urandom_range(0, 3));
        tick();
        exp_v = pack(1'b1, cur, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
             cfg_timeout} !== exp_v) begin
          n_bad++;
          $display("FAIL random_idle: got %h expected %h",
                   {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
                    cfg_timeout}, exp_v);
        end
      end
      {rx_busy, tx_busy} = 2'b00;
    end
  endtask

  task automatic test_reset_mid_clear();
    int d;
    logic [16:0] exp_v;
    d = (cur == 400) ? 401 : 400;
    req_valid = 1'b1;
    req_dvsr  = DW'(d);
    tick();                       // DRAIN, UART idle
    req_valid = 1'b0;
    tick();                       // first CLEAR cycle
    n_cmp++;
    if ({gen_clear, dvsr} !== {1'b1, DW'(d)}) begin
      n_bad++;
      $display("FAIL mid_clear_entry: got gc=%b dvsr=%0d expected gc=1 dvsr=%0d",
               gen_clear, dvsr, d);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_v = pack(1'b1, DEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
           cfg_timeout} !== exp_v) begin
        n_bad++;
        $display("FAIL mid_clear_reset i=%0d: got %h expected %h", i,
                 {req_ready, dvsr, gen_clear, cfg_busy, cfg_done, cfg_err,
                  cfg_timeout}, exp_v);
      end
      tick();
    end
    cur = DEF;
  endtask

  initial begin
    test_reset();
    test_reject();
    test_same();
    test_change();
    test_drain();
    test_timeout();
    test_random();
    test_reset_mid_clear();
    run_req(500, 3, 2'b01, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_baud_rate_ctrl
`default_nettype wire
